// File: rtl/prince_iter_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : prince_iter_engine_if
// Brief    : Block/key input and result output handshake bundle for the engine.
// Revision : 1.0
// ============================================================================
interface prince_iter_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic         in_dec;
    logic [63:0]  in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic         busy;

    modport master (
        output in_valid, in_dec, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_dec, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/prince_iter_engine.sv
`default_nettype none
// ============================================================================
// Module   : prince_iter_engine
// Brief    : Iterative PRINCE encrypt/decrypt engine, UNROLL round-steps/clock.
// Revision : 1.0
// ============================================================================
module prince_iter_engine #(
    parameter int UNROLL = 1
) (
    input  logic                clk,
    input  logic                rst,
    prince_iter_engine_if.slave eng
);
    localparam int          c_N_STEPS   = 11;
    localparam logic [63:0] c_ALPHA     = 64'hC0AC29B7C97C50DD;
    localparam logic [63:0] c_SBOX      = 64'h4D5E087619CA23FB;
    localparam logic [63:0] c_SBOX_INV  = 64'h1CE5046A98DF237B;
    localparam logic [1:0]  c_ST_IDLE   = 2'd0;
    localparam logic [1:0]  c_ST_RUN    = 2'd1;
    localparam logic [1:0]  c_ST_DONE   = 2'd2;

    if (UNROLL < 1 || UNROLL > c_N_STEPS) begin : g_bad_unroll
        $error("prince_iter_engine: UNROLL must lie in 1..11");
    end

    // Nibble x of the table constants holds the S-box entry for input x.
    function automatic logic [63:0] s_layer_f(input logic [63:0] s, input logic inv);
        logic [63:0] r;
        logic [63:0] tbl;
        tbl = inv ? c_SBOX_INV : c_SBOX;
        r   = '0;
        for (int n = 0; n < 16; n++) begin
            r[4*n +: 4] = tbl[{s[4*n +: 4], 2'b00} +: 4];
        end
        return r;
    endfunction

    function automatic logic [15:0] mhat_f(input logic [15:0] w, input logic sel);
        logic [15:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            for (int b = 0; b < 4; b++) begin
                for (int k = 0; k < 4; k++) begin
                    if (b != ((j + k + (sel ? 1 : 0)) % 4)) begin
                        r[15-4*j-b] = r[15-4*j-b] ^ w[15-4*k-b];
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] mprime_f(input logic [63:0] s);
        return {mhat_f(s[63:48], 1'b0), mhat_f(s[47:32], 1'b1),
                mhat_f(s[31:16], 1'b1), mhat_f(s[15:0],  1'b0)};
    endfunction

    // Nibble 0 is the most significant; rows are nibble index mod 4.
    function automatic logic [63:0] sr_f(input logic [63:0] s, input logic inv);
        logic [63:0] r;
        int          src;
        r = '0;
        for (int m = 0; m < 16; m++) begin
            src = inv ? (m + 16 - 4*(m % 4)) % 16 : (m + 4*(m % 4)) % 16;
            r[63-4*m -: 4] = s[63-4*src -: 4];
        end
        return r;
    endfunction

    function automatic logic [63:0] rc_f(input logic [3:0] i);
        logic [63:0] r;
        case (i)
            4'd1:    r = 64'h13198A2E03707344;
            4'd2:    r = 64'hA4093822299F31D0;
            4'd3:    r = 64'h082EFA98EC4E6C89;
            4'd4:    r = 64'h452821E638D01377;
            4'd5:    r = 64'hBE5466CF34E90C6C;
            4'd6:    r = 64'h7EF84F78FD955CB1;
            4'd7:    r = 64'h85840851F1AC43AA;
            4'd8:    r = 64'hC882D32F25323C54;
            4'd9:    r = 64'h64A51195E0E3610D;
            4'd10:   r = 64'hD3B5A399CA0C2399;
            4'd11:   r = 64'hC0AC29B7C97C50DD;
            default: r = 64'h0;
        endcase
        return r;
    endfunction

    // Indices past the last round are padding slots and pass the state through.
    function automatic logic [63:0] step_f(input logic [63:0] s, input logic [4:0] idx,
                                           input logic [63:0] kc);
        logic [63:0] r;
        if (idx < 5'd5) begin
            r = sr_f(mprime_f(s_layer_f(s, 1'b0)), 1'b0) ^ rc_f(idx[3:0] + 4'd1) ^ kc;
        end else if (idx == 5'd5) begin
            r = s_layer_f(mprime_f(s_layer_f(s, 1'b0)), 1'b1);
        end else if (idx <= 5'd10) begin
            r = s_layer_f(mprime_f(sr_f(s ^ rc_f(idx[3:0]) ^ kc, 1'b1)), 1'b1);
        end else begin
            r = s;
        end
        return r;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] blk_q, blk_d;
    logic [63:0] kc_q, kc_d;
    logic [63:0] kout_q, kout_d;
    logic [63:0] out_data_q, out_data_d;

    logic [63:0] w_k0, w_k1, w_k0p;
    logic [4:0]  w_cnt_sum;
    logic        w_last;
    logic [63:0] w_chain [0:UNROLL];

    assign w_k0      = eng.in_key[127:64];
    assign w_k1      = eng.in_key[63:0];
    assign w_k0p     = {w_k0[0], w_k0[63:1]} ^ {63'b0, w_k0[63]};
    assign w_cnt_sum = {1'b0, cnt_q} + 5'(UNROLL);
    assign w_last    = (w_cnt_sum >= 5'(c_N_STEPS));

    assign w_chain[0] = blk_q;
    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        assign w_chain[g+1] = step_f(w_chain[g], {1'b0, cnt_q} + 5'(g), kc_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: if (eng.in_valid)  state_d = c_ST_RUN;
            c_ST_RUN:  if (w_last)        state_d = c_ST_DONE;
            c_ST_DONE: if (eng.out_ready) state_d = c_ST_IDLE;
            default:                      state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        eng.in_ready  = (state_q == c_ST_IDLE);
        eng.out_valid = (state_q == c_ST_DONE);
        eng.busy      = (state_q == c_ST_RUN) || (state_q == c_ST_DONE);
        eng.out_data  = out_data_q;
    end

    // Decryption reuses the encryption datapath: swap whitening keys, fold alpha into kc.
    always_comb begin
        cnt_d      = cnt_q;
        blk_d      = blk_q;
        kc_d       = kc_q;
        kout_d     = kout_q;
        out_data_d = out_data_q;
        if (state_q == c_ST_IDLE && eng.in_valid) begin
            kc_d   = eng.in_dec ? (w_k1 ^ c_ALPHA) : w_k1;
            kout_d = eng.in_dec ? w_k0 : w_k0p;
            blk_d  = eng.in_data ^ (eng.in_dec ? w_k0p : w_k0) ^ kc_d;
            cnt_d  = 4'd0;
        end else if (state_q == c_ST_RUN) begin
            blk_d = w_chain[UNROLL];
            cnt_d = w_last ? 4'(c_N_STEPS) : w_cnt_sum[3:0];
            if (w_last) begin
                out_data_d = w_chain[UNROLL] ^ rc_f(4'd11) ^ kc_q ^ kout_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            blk_q      <= '0;
            kc_q       <= '0;
            kout_q     <= '0;
            out_data_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            blk_q      <= blk_d;
            kc_q       <= kc_d;
            kout_q     <= kout_d;
            out_data_q <= out_data_d;
        end
    end
endmodule
`default_nettype wire
